// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: result codes, sequencer states, winning lines and
// the cell-to-board-bit mapping used by every block that touches the board.
package ttt_pkg;

    localparam logic [1:0] RES_PLAY = 2'b00;
    localparam logic [1:0] RES_XWIN = 2'b01;
    localparam logic [1:0] RES_OWIN = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CHECK,
        ST_WRITE,
        ST_JUDGE,
        ST_OVER
    } state_t;

    // Cell triples (1..9): rows, columns, diagonals
    localparam logic [3:0] WIN_LINES [8][3] = '{
        '{4'd1, 4'd2, 4'd3}, '{4'd4, 4'd5, 4'd6}, '{4'd7, 4'd8, 4'd9},
        '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8}, '{4'd3, 4'd6, 4'd9},
        '{4'd1, 4'd5, 4'd9}, '{4'd3, 4'd5, 4'd7}
    };

    // Cell k occupies bits {19-2k (O), 18-2k (X)}
    function automatic logic [4:0] cell_bit(input logic [3:0] k, input logic is_o);
        logic [4:0] lo;
        lo = 5'd18 - {k, 1'b0};
        return is_o ? lo + 5'd1 : lo;
    endfunction

endpackage

// File: rtl/ttt_line_checker.sv
// Combinational three-in-a-row detector over one player's 9 marks (bit i = cell i+1).
module ttt_line_checker
    import ttt_pkg::*;
(
    input  logic [8:0] marks,
    output logic       win
);

    always_comb begin
        win = 1'b0;
        for (int l = 0; l < 8; l++) begin
            if (marks[WIN_LINES[l][0] - 4'd1] &&
                marks[WIN_LINES[l][1] - 4'd1] &&
                marks[WIN_LINES[l][2] - 4'd1])
                win = 1'b1;
        end
    end

endmodule

// File: rtl/ttt_move_sequencer.sv
// Tic-tac-toe move sequencer: debounces keypad presses, places marks on the board,
// alternates turns and judges win/draw. Sole writer of board, is_turn_o and result.
module ttt_move_sequencer
    import ttt_pkg::*;
#(
    parameter int KEY_STABLE_CYC = 3,
    parameter bit FIRST_IS_O     = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  key_data,
    input  logic        is_main,
    input  logic        new_game,
    output logic [17:0] board,
    output logic        is_turn_o,
    output logic [1:0]  result,
    output logic        move_ok,
    output logic        move_rej
);

    localparam int          CW  = $clog2(KEY_STABLE_CYC + 1);
    localparam logic [CW:0] KSC = (CW + 1)'(KEY_STABLE_CYC);

    state_t        state, state_n;
    logic [3:0]    prev_key, cur_k, cur_k_n;
    logic [CW-1:0] cnt;
    logic [CW:0]   hit_cnt;
    logic          armed, key_vld, hit, acc;
    logic [17:0]   board_n;
    logic          turn_n, ok_n, rej_n, win;
    logic [1:0]    result_n;
    logic [8:0]    mover_marks, occupied;

    always_comb begin
        key_vld = (key_data != 4'd0) && (key_data <= 4'd9);
        hit_cnt = '0;
        if (key_vld)
            hit_cnt = (key_data == prev_key) ? {1'b0, cnt} + 1'b1 : (CW + 1)'(1);
        hit = armed && (hit_cnt == KSC);
        acc = hit && (state != ST_IDLE);
    end

    // A qualified press disarms the qualifier until the key is released
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_key <= 4'd0;
            cnt      <= '0;
            armed    <= 1'b1;
        end else begin
            prev_key <= key_data;
            cnt      <= (hit_cnt >= KSC) ? KSC[CW-1:0] : hit_cnt[CW-1:0];
            if (key_data == 4'd0)
                armed <= 1'b1;
            else if (hit)
                armed <= 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            mover_marks[i] = board[cell_bit(4'(i + 1), is_turn_o)];
            occupied[i]    = board[5'(2 * i)] | board[5'(2 * i + 1)];
        end
    end

    ttt_line_checker u_line_checker (
        .marks (mover_marks),
        .win   (win)
    );

    // Outputs are registered: each state's effect is loaded on the edge entering it,
    // so the mark shows in WRITE and the verdict shows in JUDGE.
    always_comb begin
        state_n  = state;
        board_n  = board;
        turn_n   = is_turn_o;
        result_n = result;
        ok_n     = 1'b0;
        rej_n    = 1'b0;
        cur_k_n  = cur_k;
        case (state)
            ST_IDLE: if (!is_main) state_n = ST_WAIT;
            ST_WAIT: begin
                if (is_main) begin
                    state_n = ST_IDLE;
                end else if (acc) begin
                    cur_k_n = key_data;
                    state_n = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (board[cell_bit(cur_k, 1'b1)] || board[cell_bit(cur_k, 1'b0)]) begin
                    rej_n   = 1'b1;
                    state_n = is_main ? ST_IDLE : ST_WAIT;
                end else begin
                    board_n[cell_bit(cur_k, is_turn_o)] = 1'b1;
                    ok_n    = 1'b1;
                    state_n = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (win)
                    result_n = is_turn_o ? RES_OWIN : RES_XWIN;
                else if (&occupied)
                    result_n = RES_DRAW;
                else
                    turn_n = ~is_turn_o;
                state_n = ST_JUDGE;
            end
            ST_JUDGE: begin
                if (result != RES_PLAY) state_n = ST_OVER;
                else                    state_n = is_main ? ST_IDLE : ST_WAIT;
            end
            ST_OVER: if (acc) rej_n = 1'b1;
            default: state_n = ST_IDLE;
        endcase
        if (new_game) begin
            board_n  = '0;
            result_n = RES_PLAY;
            turn_n   = FIRST_IS_O;
            ok_n     = 1'b0;
            rej_n    = 1'b0;
            state_n  = is_main ? ST_IDLE : ST_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            board     <= '0;
            is_turn_o <= FIRST_IS_O;
            result    <= RES_PLAY;
            move_ok   <= 1'b0;
            move_rej  <= 1'b0;
            cur_k     <= 4'd0;
        end else begin
            state     <= state_n;
            board     <= board_n;
            is_turn_o <= turn_n;
            result    <= result_n;
            move_ok   <= ok_n;
            move_rej  <= rej_n;
            cur_k     <= cur_k_n;
        end
    end

endmodule
